// File: rtl/dbi_pxl_dma_writer.sv
// dbi_pxl_dma_writer: packs a grayscale pixel stream into DMA_DATA_W beats,
// buffers up to BURST_LEN beats and writes them as AXI4 bursts (AW/W/B) to the
// DBI TX controller's FIFO-mapped data window.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pxl_dat/vld/last_i, pxl_rdy_o  pixel stream in (last = end of frame)
//   m_aw*                      AW channel (id/addr constant, len = beats-1)
//   m_w*                       W channel
//   m_b*                       B channel
//   frm_done_o                 one-cycle pulse on B of a frame's final burst
//   err_o                      sticky write-response error (bad BRESP or BID)
// Build option: define DBI_PXL_DMA_MSB_FIRST_EN to pack pixel 0 into the top
// lane (padding then occupies the low lanes); default is LSB-first packing.
module dbi_pxl_dma_writer #(
  parameter int unsigned          DMA_DATA_W       = 256,
  parameter int unsigned          PXL_W            = 8,
  parameter int unsigned          ADDR_W           = 32,
  parameter int unsigned          MST_ID_W         = 5,
  parameter int unsigned          TRANS_DATA_LEN_W = 8,
  parameter int unsigned          TRANS_RESP_W     = 2,
  parameter logic [MST_ID_W-1:0]  MST_ID           = '0,
  parameter logic [ADDR_W-1:0]    DST_ADDR         = 32'h2000_0000,
  parameter int unsigned          BURST_LEN        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PXL_W-1:0]            pxl_dat_i,
  input  logic                        pxl_vld_i,
  input  logic                        pxl_last_i,
  output logic                        pxl_rdy_o,
  output logic [MST_ID_W-1:0]         m_awid_o,
  output logic [ADDR_W-1:0]           m_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [DMA_DATA_W-1:0]       m_wdata_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [MST_ID_W-1:0]         m_bid_i,
  input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  output logic                        frm_done_o,
  output logic                        err_o
);

  localparam int unsigned NPX   = DMA_DATA_W / PXL_W;
  localparam int unsigned IDX_W = (NPX > 1) ? $clog2(NPX) : 1;
  localparam int unsigned PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        pk_idx;
  logic [DMA_DATA_W-1:0]   pk_acc;
  logic [DMA_DATA_W-1:0]   pk_beat_c;
  int unsigned             pk_lane_c;
  logic                    px_acc_c;
  logic                    push_c;
  logic                    pop_c;
  logic                    b_hs_c;
  logic [DMA_DATA_W-1:0]   fifo_mem [BURST_LEN];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [CNT_W-1:0]        fifo_cnt_nxt_c;
  logic                    eof_pending;
  logic                    eof_nxt_c;
  logic [CNT_W-1:0]        beats_left;
  logic                    is_final;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BURST_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_awid_o   = MST_ID;
  assign m_awaddr_o = DST_ADDR;
  // Data is forced to zero outside W so nothing stale leaks during reset/idle.
  assign m_wdata_o  = m_wvalid_o ? fifo_mem[rd_ptr] : '0;

  assign px_acc_c = pxl_vld_i & pxl_rdy_o;
  assign push_c   = px_acc_c & ((pk_idx == IDX_W'(NPX - 1)) | pxl_last_i);
  assign pop_c    = m_wvalid_o & m_wready_i;
  assign b_hs_c   = m_bready_o & m_bvalid_i;

  // Current beat with the incoming pixel merged into its lane.
  always_comb begin
    pk_beat_c = pk_acc;
`ifdef DBI_PXL_DMA_MSB_FIRST_EN
    pk_lane_c = NPX - 1 - 32'(pk_idx);
`else
    pk_lane_c = 32'(pk_idx);
`endif
    pk_beat_c[pk_lane_c*PXL_W +: PXL_W] = pxl_dat_i;
  end

  // Next FIFO occupancy and end-of-frame state feed the registered ready.
  always_comb begin
    fifo_cnt_nxt_c = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
    eof_nxt_c      = eof_pending;
    if (px_acc_c && pxl_last_i) eof_nxt_c = 1'b1;
    if (b_hs_c && is_final)     eof_nxt_c = 1'b0;
  end

  // Packer, FIFO pointers and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_idx      <= '0;
      pk_acc      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      eof_pending <= 1'b0;
      pxl_rdy_o   <= 1'b0;
    end else begin
      if (px_acc_c) begin
        if (push_c) begin
          pk_idx <= '0;
          pk_acc <= '0;
        end else begin
          pk_idx <= pk_idx + 1'b1;
          pk_acc <= pk_beat_c;
        end
      end
      if (push_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt    <= fifo_cnt_nxt_c;
      eof_pending <= eof_nxt_c;
      pxl_rdy_o   <= (fifo_cnt_nxt_c != CNT_W'(BURST_LEN)) & ~eof_nxt_c;
    end
  end

  // Beat storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= pk_beat_c;
  end

  // Burst sequencer: one burst outstanding, AW then W then B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      m_awlen_o   <= '0;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_wlast_o   <= 1'b0;
      m_bready_o  <= 1'b0;
      frm_done_o  <= 1'b0;
      err_o       <= 1'b0;
      beats_left  <= '0;
      is_final    <= 1'b0;
    end else begin
      frm_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Occupancy never exceeds BURST_LEN, so the latched length needs no
          // cap and any end-of-frame burst already holds all remaining beats.
          if ((fifo_cnt == CNT_W'(BURST_LEN)) || (eof_pending && (fifo_cnt != '0))) begin
            m_awlen_o   <= TRANS_DATA_LEN_W'(fifo_cnt - 1'b1);
            beats_left  <= fifo_cnt;
            is_final    <= eof_pending;
            m_awvalid_o <= 1'b1;
            state       <= ST_AW;
          end
        end
        ST_AW: begin
          if (m_awready_i) begin
            m_awvalid_o <= 1'b0;
            m_wvalid_o  <= 1'b1;
            m_wlast_o   <= (beats_left == CNT_W'(1));
            state       <= ST_W;
          end
        end
        ST_W: begin
          if (m_wready_i) begin
            if (beats_left == CNT_W'(1)) begin
              m_wvalid_o <= 1'b0;
              m_wlast_o  <= 1'b0;
              m_bready_o <= 1'b1;
              state      <= ST_B;
            end else begin
              beats_left <= beats_left - 1'b1;
              m_wlast_o  <= (beats_left == CNT_W'(2));
            end
          end
        end
        ST_B: begin
          if (m_bvalid_i) begin
            m_bready_o <= 1'b0;
            if ((m_bresp_i != '0) || (m_bid_i != MST_ID)) err_o <= 1'b1;
            frm_done_o <= is_final;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbi_pxl_dma_writer.md
Name: dbi_pxl_dma_writer

Overview:
- Upstream feeder for the DBI TX controller's AXI4 DMA data port.
- Accepts a grayscale pixel stream from the camera pipeline and packs pixels LSB-first into DMA_DATA_W beats in a BURST_LEN-deep beat FIFO.
- Issues AXI4 write bursts (AW/W/B) to the controller's FIFO-mapped data window.
- Handles end-of-frame flush with zero padding and a short final burst, and reports write-response errors.

Parameters:
- DMA_DATA_W, 256, AXI data width; must be a multiple of PXL_W.
- PXL_W, 8, pixel width.
- ADDR_W, 32, AXI address width.
- MST_ID_W, 5, AXI ID width.
- TRANS_DATA_LEN_W, 8, AWLEN width.
- TRANS_RESP_W, 2, BRESP width.
- MST_ID, 0, ID driven on AWID and expected on BID.
- DST_ADDR, 32'h2000_0000, address driven on every AW.
- BURST_LEN, 16, maximum beats per burst and FIFO depth; range 1..2^TRANS_DATA_LEN_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pxl_dat_i  in  PXL_W  pixel data
- pxl_vld_i  in  1  pixel valid
- pxl_last_i  in  1  last pixel of frame; qualified by pxl_vld_i & pxl_rdy_o
- pxl_rdy_o  out  1  pixel ready
- m_awid_o  out  MST_ID_W  AW ID, constant MST_ID
- m_awaddr_o  out  ADDR_W  AW address, constant DST_ADDR
- m_awlen_o  out  TRANS_DATA_LEN_W  beats-1
- m_awvalid_o  out  1  AW valid
- m_awready_i  in  1  AW ready
- m_wdata_o  out  DMA_DATA_W  W data
- m_wlast_o  out  1  last beat of burst
- m_wvalid_o  out  1  W valid
- m_wready_i  in  1  W ready
- m_bid_i  in  MST_ID_W  B ID
- m_bresp_i  in  TRANS_RESP_W  B response
- m_bvalid_i  in  1  B valid
- m_bready_o  out  1  B ready
- frm_done_o  out  1  one-cycle pulse on B of a frame's final burst
- err_o  out  1  sticky error flag

Behaviour:
- Reset: the reset is asynchronous and active-low; one clock (clk). While rst_n is low, all outputs are 0 except the constants m_awid_o and m_awaddr_o. Packer index, FIFO, state, eof_pending and err are cleared. Assertion mid-burst drops every valid immediately; any partial beat is lost.
- Packer, pixel acceptance: a pixel is accepted when pxl_vld_i & pxl_rdy_o. Pixel k of a beat lands at bits [k*PXL_W +: PXL_W], index 0..N-1 with N = DMA_DATA_W/PXL_W.
- Packer, beat push: on the Nth pixel, or on an accepted pxl_last_i, the beat is pushed to the FIFO. Unfilled lanes are zero. The index returns to 0.
- Packer, last pixel: pxl_last_i together with the Nth pixel pushes exactly one beat; no extra padding beat.
- pxl_rdy_o = !fifo_full & !eof_pending. It is registered-state only and has no combinational path from the AXI inputs.
- eof_pending: set on an accepted pxl_last_i. Cleared when the FIFO is empty and B has been taken for the final burst; frm_done_o pulses that same cycle.
- FIFO: depth BURST_LEN. Simultaneous push and pop are allowed. No push when full, because the packer is stalled.
- FSM IDLE: go to AW when count==BURST_LEN, or when eof_pending & count>0. Latch len=count, capped at BURST_LEN, and is_final = eof_pending & (count<=BURST_LEN).
- FSM AW: m_awvalid_o=1 and m_awlen_o=len-1, held stable until m_awready_i. Then go to W. AW is asserted the cycle after the IDLE decision.
- FSM W: m_wvalid_o=1 and m_wdata_o=FIFO head. Pop on wready. m_wlast_o=1 on beat len. After the last handshake go to B. wvalid stays high throughout the burst, because len beats are guaranteed present.
- FSM B: m_bready_o=1. On m_bvalid_i go to IDLE.
  - m_bresp_i!=0 or m_bid_i!=MST_ID sets err_o; err_o clears only on reset.
  - If is_final, pulse frm_done_o.
- One burst is outstanding at a time. AW and W are never concurrent.
- The packer keeps filling the FIFO during AW/W/B while not full and not eof_pending.
- Zero-length frame: pxl_last_i on pixel 0 still pushes one beat, with pixel 0 in lane 0.

Optional Feature:
- Macro: DBI_PXL_DMA_MSB_FIRST_EN.
- Defined: pixel k lands at bits [(N-1-k)*PXL_W +: PXL_W] (MSB-first). Padding fills the low lanes with zero.
- Undefined: LSB-first packing as above. All other behaviour is identical.

Test Plan:
- 512 pixels (value = index mod 256), last on pixel 511, all ready high:
  - one AW with awlen=15 and awaddr=0x2000_0000;
  - 16 W beats, beat0[7:0]=0x00 and beat0[255:248]=0x1F;
  - wlast only on beat 16;
  - frm_done_o pulses once, on bvalid.
- 40 pixels with last on pixel 39:
  - awlen=1;
  - beat1 lanes 0..7 = pixels 32..39 and lanes 8..31 = 0;
  - pxl_rdy_o=0 from eof until frm_done_o.
- 600 pixels with awready held low 20 cycles:
  - awvalid and awlen stay stable;
  - pxl_rdy_o drops once the FIFO is full (512 pixels packed plus in-flight);
  - bursts have awlen=15 then awlen=2, in that order.
- wready toggling 1/0 each cycle:
  - beats are emitted in order with no loss or duplication;
  - wlast aligns with the final handshake.
- bresp=2'b10 on the first burst: err_o goes 1 and stays 1 across later OKAY responses; with bid=3 instead, err_o is also set.
- rst_n pulsed low mid-W:
  - wvalid, awvalid, bready and pxl_rdy_o go 0 asynchronously;
  - after release, a fresh 512-pixel frame produces exactly 16 beats.
